// File: rtl/ex_div.sv
// ex_div: multi-cycle 32-bit restoring divider for DIV/DIVU, result = {remainder, quotient}.
// Define EX_DIV_SIGNED_EN to honour signed_div_i (absolute-value capture plus sign correction).
module ex_div (
   input  logic        clk,
   input  logic        rst,
   input  logic        signed_div_i,
   input  logic [31:0] opdata1_i,
   input  logic [31:0] opdata2_i,
   input  logic        start_i,
   input  logic        annul_i,
   output logic [63:0] result_o,
   output logic        ready_o
);

   typedef enum logic [1:0] {FREE, BY_ZERO, ON, END} state_t;

   state_t      r_state;
   state_t      w_nextState;
   logic [5:0]  r_cnt;
   logic [5:0]  w_cntNext;
   logic [63:0] r_work;
   logic [63:0] w_workNext;
   logic [31:0] r_divisor;
   logic [31:0] w_divisorNext;
   logic [63:0] w_resultNext;
   logic        w_readyNext;
   logic [31:0] w_absDividend;
   logic [31:0] w_absDivisor;
   logic [31:0] w_quot;
   logic [31:0] w_rem;
   logic        w_fits;
   logic [31:0] w_diff;

`ifdef EX_DIV_SIGNED_EN
   logic r_negQuot;
   logic r_negRem;
   logic w_negQuotNext;
   logic w_negRemNext;

   assign w_absDividend = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
   assign w_absDivisor  = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;
   assign w_quot        = r_negQuot ? (~r_work[31:0] + 32'd1) : r_work[31:0];
   assign w_rem         = r_negRem ? (~r_work[63:32] + 32'd1) : r_work[63:32];
`else
   assign w_absDividend = opdata1_i;
   assign w_absDivisor  = opdata2_i;
   assign w_quot        = r_work[31:0];
   assign w_rem         = r_work[63:32];
`endif

   // One step shifts the next dividend bit into the partial remainder and subtracts when it fits;
   // the 33-bit compare covers a shifted remainder that overflows 32 bits.
   assign w_fits = (r_work[63:31] >= {1'b0, r_divisor});
   assign w_diff = r_work[62:31] - r_divisor;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= FREE;
         r_cnt     <= 6'd0;
         r_work    <= 64'd0;
         r_divisor <= 32'd0;
         result_o  <= 64'd0;
         ready_o   <= 1'b0;
`ifdef EX_DIV_SIGNED_EN
         r_negQuot <= 1'b0;
         r_negRem  <= 1'b0;
`endif
      end else begin
         r_state   <= w_nextState;
         r_cnt     <= w_cntNext;
         r_work    <= w_workNext;
         r_divisor <= w_divisorNext;
         result_o  <= w_resultNext;
         ready_o   <= w_readyNext;
`ifdef EX_DIV_SIGNED_EN
         r_negQuot <= w_negQuotNext;
         r_negRem  <= w_negRemNext;
`endif
      end
   end

   always_comb begin
      w_nextState   = r_state;
      w_cntNext     = r_cnt;
      w_workNext    = r_work;
      w_divisorNext = r_divisor;
      w_resultNext  = result_o;
      w_readyNext   = ready_o;
`ifdef EX_DIV_SIGNED_EN
      w_negQuotNext = r_negQuot;
      w_negRemNext  = r_negRem;
`endif
      case (r_state)
         FREE: begin
            w_readyNext  = 1'b0;
            w_resultNext = 64'd0;
            if (start_i && !annul_i) begin
               if (opdata2_i == 32'd0) begin
                  w_nextState = BY_ZERO;
               end else begin
                  w_nextState   = ON;
                  w_cntNext     = 6'd0;
                  w_workNext    = {32'd0, w_absDividend};
                  w_divisorNext = w_absDivisor;
`ifdef EX_DIV_SIGNED_EN
                  w_negQuotNext = signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
                  w_negRemNext  = signed_div_i && opdata1_i[31];
`endif
               end
            end
         end
         BY_ZERO: begin
            w_workNext  = 64'd0;
            w_nextState = END;
`ifdef EX_DIV_SIGNED_EN
            w_negQuotNext = 1'b0;
            w_negRemNext  = 1'b0;
`endif
         end
         ON: begin
            if (annul_i) begin
               w_nextState = FREE;
               w_cntNext   = 6'd0;
               w_workNext  = 64'd0;
            end else begin
               if (w_fits) begin
                  w_workNext = {w_diff, r_work[30:0], 1'b1};
               end else begin
                  w_workNext = {r_work[62:0], 1'b0};
               end
               w_cntNext = r_cnt + 6'd1;
               if (r_cnt == 6'd31) begin
                  w_nextState = END;
               end
            end
         end
         END: begin
            if (start_i) begin
               w_readyNext  = 1'b1;
               w_resultNext = {w_rem, w_quot};
            end else begin
               w_readyNext  = 1'b0;
               w_resultNext = 64'd0;
               w_nextState  = FREE;
            end
         end
         default: begin
            w_nextState = FREE;
         end
      endcase
   end

endmodule

// File: tb/tb_ex_div.sv
// tb_ex_div: randomized and directed checks of ex_div against a plain-arithmetic divide model.
// Honours EX_DIV_SIGNED_EN the same way as the design.
module tb_ex_div;

   logic        clk;
   logic        rst;
   logic        signed_div_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic        start_i;
   logic        annul_i;
   logic [63:0] result_o;
   logic        ready_o;

   int tests;
   int failures;

   ex_div dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .result_o     (result_o),
      .ready_o      (ready_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%016h, expected 0x%016h", tag, got, exp);
      end
   endtask

   // Reference: quotient truncates toward zero, remainder follows the dividend, x/0 gives zeros.
   function automatic logic [63:0] refDiv(input logic sgn, input logic [31:0] a, input logic [31:0] b);
      longint sa;
      longint sb;
      longint q;
      longint r;
      if (b == 32'd0) return 64'd0;
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
`ifdef EX_DIV_SIGNED_EN
      if (sgn) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end
`endif
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   task automatic applyStimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                input logic [63:0] exp, input string tag);
      @(negedge clk);
      signed_div_i = sgn;
      opdata1_i    = a;
      opdata2_i    = b;
      start_i      = 1'b1;
      @(posedge clk);
      @(negedge clk);
      signed_div_i = ~sgn;
      opdata1_i    = $urandom;
      opdata2_i    = $urandom;
      if (b != 32'd0) begin
         repeat (32) @(posedge clk);
         #1 checkOutput({tag, " ready early"}, {63'd0, ready_o}, 64'd0);
         @(posedge clk);
      end else begin
         @(posedge clk);
         #1 checkOutput({tag, " ready early"}, {63'd0, ready_o}, 64'd0);
         repeat (2) @(posedge clk);
      end
      #1;
      checkOutput({tag, " ready"}, {63'd0, ready_o}, 64'd1);
      checkOutput({tag, " result"}, result_o, exp);
      @(posedge clk);
      #1;
      checkOutput({tag, " hold ready"}, {63'd0, ready_o}, 64'd1);
      checkOutput({tag, " hold result"}, result_o, exp);
      @(negedge clk);
      start_i = 1'b0;
      @(posedge clk);
      #1;
      checkOutput({tag, " drop ready"}, {63'd0, ready_o}, 64'd0);
      checkOutput({tag, " drop result"}, result_o, 64'd0);
   endtask

   initial begin
      logic        sgn;
      logic [31:0] a;
      logic [31:0] b;
      logic        sawReady;
      logic [63:0] expSigned;
      logic [63:0] expOverflow;

      tests        = 0;
      failures     = 0;
      rst          = 1'b1;
      signed_div_i = 1'b0;
      opdata1_i    = 32'd0;
      opdata2_i    = 32'd0;
      start_i      = 1'b0;
      annul_i      = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset ready", {63'd0, ready_o}, 64'd0);
      checkOutput("reset result", result_o, 64'd0);
      @(negedge clk);
      rst = 1'b0;

`ifdef EX_DIV_SIGNED_EN
      expSigned   = 64'hFFFFFFFF_FFFFFFFD;
      expOverflow = 64'h00000000_80000000;
`else
      expSigned   = 64'h00000001_7FFFFFFC;
      expOverflow = 64'h80000000_00000000;
`endif
      applyStimulus(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, "divu 100/7");
      applyStimulus(1'b1, 32'hFFFFFFF9, 32'd2, expSigned, "div -7/2");
      applyStimulus(1'b1, 32'h00001234, 32'd0, 64'd0, "div by zero");
      applyStimulus(1'b1, 32'h80000000, 32'hFFFFFFFF, expOverflow, "overflow");
      applyStimulus(1'b0, 32'hFFFFFFFF, 32'd1, refDiv(1'b0, 32'hFFFFFFFF, 32'd1), "divu max/1");

      // Annul partway through: ready must stay low, then a fresh request works.
      @(negedge clk);
      signed_div_i = 1'b0;
      opdata1_i    = 32'd1000;
      opdata2_i    = 32'd3;
      start_i      = 1'b1;
      @(posedge clk);
      repeat (9) @(posedge clk);
      @(negedge clk);
      annul_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      annul_i  = 1'b0;
      start_i  = 1'b0;
      sawReady = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1 if (ready_o) sawReady = 1'b1;
      end
      checkOutput("annul no ready", {63'd0, sawReady}, 64'd0);
      applyStimulus(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, "after annul 9/3");

      // Reset mid-division, then reset while a result is being held.
      @(negedge clk);
      opdata1_i = 32'd5000;
      opdata2_i = 32'd7;
      start_i   = 1'b1;
      @(posedge clk);
      repeat (15) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      checkOutput("rst mid ready", {63'd0, ready_o}, 64'd0);
      checkOutput("rst mid result", result_o, 64'd0);
      @(negedge clk);
      start_i = 1'b0;
      rst     = 1'b0;
      @(negedge clk);
      start_i = 1'b1;
      @(posedge clk);
      repeat (33) @(posedge clk);
      #1;
      checkOutput("pre-rst result", result_o, refDiv(1'b0, 32'd5000, 32'd7));
      #2 rst = 1'b1;
      #1;
      checkOutput("rst held ready", {63'd0, ready_o}, 64'd0);
      checkOutput("rst held result", result_o, 64'd0);
      @(negedge clk);
      start_i = 1'b0;
      rst     = 1'b0;
      applyStimulus(1'b0, 32'd77, 32'd10, 64'h00000007_00000007, "after rst 77/10");

      for (int i = 0; i < 20; i++) begin
         sgn = 1'($urandom_range(0, 1));
         a   = $urandom;
         b   = $urandom;
         case ($urandom_range(0, 4))
            0: b = $urandom_range(1, 15);
            1: b = 32'hFFFFFFFF - $urandom_range(0, 15);
            2: a = $urandom_range(0, 255);
            3: if (i % 4 == 0) b = 32'd0;
            default: ;
         endcase
         applyStimulus(sgn, a, b, refDiv(sgn, a, b), $sformatf("rand%0d", i));
      end

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
